// File: rtl/im_pkg.sv
// ---------------------------------------------------------------------------
// im_pkg
// Shared definitions for the writable instruction memory (im_fetch_mem):
//   - DATA_W_DEF     : default instruction word width
//   - FAULT_*        : 2-bit response fault encodings
//   - state_t        : fetch state machine encoding (IDLE / WAIT / RESP)
//   - fault_decode() : maps byte offset and range status to a fault code
// ---------------------------------------------------------------------------
package im_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A misaligned address is reported even when it is also out of range.
    function automatic logic [1:0] fault_decode(input logic [1:0] byte_off,
                                                input logic       in_range);
        logic [1:0] fault;
        if (byte_off != 2'b00) begin
            fault = FAULT_MISALIGN;
        end else if (!in_range) begin
            fault = FAULT_RANGE;
        end else begin
            fault = FAULT_OK;
        end
        return fault;
    endfunction

endpackage

// File: rtl/im_ram.sv
// ---------------------------------------------------------------------------
// im_ram
// DEPTH x DATA_W instruction storage. One synchronous write port and one
// combinational read port. Because the write lands with a non-blocking
// update, a read sampled on the same edge as a write to the same word sees
// the old contents (read-before-write). Contents are never reset.
// Ports:
//   clk      in   clock
//   we_i     in   write enable (caller guarantees wr_idx_i < DEPTH)
//   wr_idx_i in   write word index
//   wr_data_i in  write data
//   rd_idx_i in   read word index
//   rd_data_o out read data (combinational)
// ---------------------------------------------------------------------------
module im_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/im_fetch_mem.sv
// ---------------------------------------------------------------------------
// im_fetch_mem
// Writable instruction memory with a valid/ready fetch port, WAIT_CYC
// programmable wait states and fault reporting for misaligned or
// out-of-range fetches. A loader port writes words at any time.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready response handshake
//   rsp_data            fetched word (0 on fault), rsp_fault = fault code
//   ld_en/ld_addr/ld_data loader write strobe, word index, data
//   busy                request in flight or response pending
// ---------------------------------------------------------------------------
module im_fetch_mem
    import im_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-3:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**IDX_W is representable.
    localparam logic [IDX_W:0] DEPTH_L = DEPTH[IDX_W:0];
    localparam logic [3:0]     WAIT_L  = WAIT_CYC[3:0];
    localparam bit             NO_WAIT = (WAIT_CYC == 0);

    if (DEPTH < 1 || DEPTH > (1 << IDX_W) || WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_param_err
        $error("im_fetch_mem: DEPTH must be 1..2**(ADDR_W-2) and WAIT_CYC 0..15");
    end

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] rsp_data_d;
    logic [1:0]        rsp_fault_q;
    logic [1:0]        rsp_fault_d;

    logic              accept;
    logic              capture;
    logic [ADDR_W-1:0] fetch_addr;
    logic [IDX_W-1:0]  fetch_idx;
    logic              fetch_in_range;
    logic              ld_in_range;
    logic [DATA_W-1:0] ram_rd_data;

    assign req_ready = (state_q == IDLE) && !ld_en;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;

    // With no wait states the capture edge is the accept edge, so the
    // address comes straight from the request port instead of addr_q.
    assign fetch_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign fetch_idx  = fetch_addr[ADDR_W-1:2];

    assign capture = (NO_WAIT && accept) || ((state_q == WAIT) && (cnt_q == WAIT_L));

    assign fetch_in_range = ({1'b0, fetch_idx} < DEPTH_L);
    assign ld_in_range    = ({1'b0, ld_addr} < DEPTH_L);

    im_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk       (clk),
        .we_i      (ld_en && ld_in_range),
        .wr_idx_i  (ld_addr[RAM_AW-1:0]),
        .wr_data_i (ld_data),
        .rd_idx_i  (fetch_idx[RAM_AW-1:0]),
        .rd_data_o (ram_rd_data)
    );

    always_comb begin
        rsp_fault_d = fault_decode(fetch_addr[1:0], fetch_in_range);
        rsp_data_d  = (rsp_fault_d == FAULT_OK) ? ram_rd_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= FAULT_OK;
        end else begin
            if (capture) begin
                rsp_data_q  <= rsp_data_d;
                rsp_fault_q <= rsp_fault_d;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        if (NO_WAIT) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_L) begin
                        state_q <= RESP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_fetch_mem.sv
// ---------------------------------------------------------------------------
// tb_im_fetch_mem
// Three instances: 0 = DEPTH 42 / WAIT_CYC 1, 1 = DEPTH 64 / WAIT_CYC 0,
// 2 = DEPTH 64 / WAIT_CYC 3. Table-driven fetches plus hand-written
// sequences for back-pressure, loader blocking, collision and reset.
// ---------------------------------------------------------------------------
module tb_im_fetch_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid [3];
    logic        req_ready [3];
    logic [13:0] req_addr  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_data  [3];
    logic [1:0]  rsp_fault [3];
    logic        ld_en     [3];
    logic [11:0] ld_addr   [3];
    logic [31:0] ld_data   [3];
    logic        busy      [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        im_fetch_mem #(
            .ADDR_W   (14),
            .DATA_W   (32),
            .DEPTH    (gi == 0 ? 42 : 64),
            .WAIT_CYC (gi == 0 ? 1 : (gi == 1 ? 0 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_addr  (req_addr[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_data  (rsp_data[gi]),
            .rsp_fault (rsp_fault[gi]),
            .ld_en     (ld_en[gi]),
            .ld_addr   (ld_addr[gi]),
            .ld_data   (ld_data[gi]),
            .busy      (busy[gi])
        );
    end

    typedef struct packed {
        int          d;
        logic [13:0] addr;
        logic [31:0] data;
        logic [1:0]  fault;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  fault;
        int          lat;
    } exp_t;

    vec_t vecs [11];
    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int wc_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with DUT idle; returns at posedge+1 with DUT idle.
    task automatic load(input int d, input logic [11:0] idx, input logic [31:0] data);
        ld_en[d]   = 1'b1;
        ld_addr[d] = idx;
        ld_data[d] = data;
        @(posedge clk); #1;
        ld_en[d]   = 1'b0;
        $display("[TB] load dut%0d idx=%0d data=0x%08h", d, idx, data);
    endtask

    // Waits (bounded) at negedges for rsp_valid; n = cycles since accept edge.
    task automatic wait_rsp(input int d, output int n);
        n = 1;
        @(negedge clk);
        while (!rsp_valid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic fetch(input int d, input logic [13:0] a, input logic [31:0] ed, input logic [1:0] ef);
        int   n;
        exp_t e;
        e.data  = ed;
        e.fault = ef;
        e.lat   = 1 + wc_of(d);
        sb_q.push_back(e);
        req_addr[d]  = a;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        wait_rsp(d, n);
        e = sb_q.pop_front();
        $display("[TB] fetch dut%0d addr=0x%04h data=0x%08h fault=%0d lat=%0d", d, a, rsp_data[d], rsp_fault[d], n);
        check("fetch_latency", n, e.lat);
        check("fetch_data", rsp_data[d], e.data);
        check("fetch_fault", {30'd0, rsp_fault[d]}, {30'd0, e.fault});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t e;

        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            rsp_ready[i] = 1'b1;
            ld_en[i]     = 1'b0;
            ld_addr[i]   = '0;
            ld_data[i]   = '0;
        end

        vecs[0]  = '{0, 14'h0000, 32'hffe18113, 2'b00};
        vecs[1]  = '{0, 14'h00A4, 32'h00008297, 2'b00};
        vecs[2]  = '{0, 14'h0002, 32'h00000000, 2'b01};
        vecs[3]  = '{0, 14'h00A8, 32'h00000000, 2'b10};
        vecs[4]  = '{0, 14'h0004, 32'h00000013, 2'b00};
        vecs[5]  = '{0, 14'h00AB, 32'h00000000, 2'b01};
        vecs[6]  = '{0, 14'h3FFC, 32'h00000000, 2'b10};
        vecs[7]  = '{1, 14'h000C, 32'hcafef00d, 2'b00};
        vecs[8]  = '{1, 14'h000E, 32'h00000000, 2'b01};
        vecs[9]  = '{2, 14'h00FC, 32'h0badbeef, 2'b00};
        vecs[10] = '{2, 14'h0100, 32'h00000000, 2'b10};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("reset_rsp_data", rsp_data[0], 32'd0);
        check("reset_rsp_fault", {30'd0, rsp_fault[0]}, 32'd0);
        check("reset_busy", {31'd0, busy[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", {31'd0, req_ready[0]}, 32'd1);

        load(0, 12'd0, 32'hffe18113);
        load(0, 12'd41, 32'h00008297);
        load(0, 12'd1, 32'h00000013);
        load(0, 12'd5, 32'haaaa5555);
        load(0, 12'd7, 32'h13579bdf);
        load(0, 12'd42, 32'hdeadbeef);
        load(1, 12'd3, 32'hcafef00d);
        load(2, 12'd63, 32'h0badbeef);

        for (int i = 0; i < 11; i++) begin
            fetch(vecs[i].d, vecs[i].addr, vecs[i].data, vecs[i].fault);
        end

        // Back-pressure: response held stable while rsp_ready is low
        rsp_ready[0] = 1'b0;
        sb_q.push_back('{32'h00000013, 2'b00, 2});
        req_addr[0]  = 14'h0004;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0, n);
        e = sb_q.pop_front();
        check("bp_latency", n, e.lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            check("bp_rsp_data", rsp_data[0], e.data);
            check("bp_rsp_fault", {30'd0, rsp_fault[0]}, {30'd0, e.fault});
            check("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_valid_before_hs", {31'd0, rsp_valid[0]}, 32'd1);
        @(negedge clk);
        check("bp_valid_after_hs", {31'd0, rsp_valid[0]}, 32'd0);
        check("bp_busy_after_hs", {31'd0, busy[0]}, 32'd0);
        check("bp_data_kept", rsp_data[0], 32'h00000013);
        check("bp_req_ready_after", {31'd0, req_ready[0]}, 32'd1);
        $display("[TB] backpressure dut0 held 5 cycles data=0x%08h", rsp_data[0]);
        @(posedge clk); #1;

        // Loader write in IDLE blocks a request the same cycle
        req_addr[0]  = 14'h0000;
        req_valid[0] = 1'b1;
        ld_en[0]     = 1'b1;
        ld_addr[0]   = 12'd9;
        ld_data[0]   = 32'h00100093;
        @(negedge clk);
        check("ld_blocks_req_ready", {31'd0, req_ready[0]}, 32'd0);
        @(posedge clk); #1;
        ld_en[0]     = 1'b0;
        req_valid[0] = 1'b0;
        check("ld_blocks_accept", {31'd0, busy[0]}, 32'd0);
        $display("[TB] loader-blocked request dut0 busy=%0d", busy[0]);
        fetch(0, 14'h0024, 32'h00100093, 2'b00);

        // Collision: write on the capture edge returns the old word
        sb_q.push_back('{32'haaaa5555, 2'b00, 2});
        req_addr[0]  = 14'h0014;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        ld_en[0]     = 1'b1;
        ld_addr[0]   = 12'd5;
        ld_data[0]   = 32'h12345678;
        @(posedge clk); #1;
        ld_en[0]     = 1'b0;
        @(negedge clk);
        e = sb_q.pop_front();
        check("collision_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
        check("collision_old_word", rsp_data[0], e.data);
        $display("[TB] collision dut0 addr=0x0014 data=0x%08h", rsp_data[0]);
        @(posedge clk); #1;
        fetch(0, 14'h0014, 32'h12345678, 2'b00);

        // Reset during WAIT drops the request, memory survives
        req_addr[0]  = 14'h001C;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("wait_busy", {31'd0, busy[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_mid_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("rst_mid_rsp_data", rsp_data[0], 32'd0);
        check("rst_mid_rsp_fault", {30'd0, rsp_fault[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_no_late_rsp", {31'd0, rsp_valid[0]}, 32'd0);
        $display("[TB] reset during WAIT dut0 busy=%0d rsp_valid=%0d", busy[0], rsp_valid[0]);
        @(posedge clk); #1;
        fetch(0, 14'h001C, 32'h13579bdf, 2'b00);
        fetch(0, 14'h0000, 32'hffe18113, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
